// File: rtl/mwadd_seq.sv
// mwadd_seq: multi-word adder that reuses one external 8-bit carry-propagate
// adder, one slice per clock, least-significant slice first.
//
// Optional feature: define MWADD_OVF_EN to compute signed overflow from the
// top slice (slice_c7 ^ slice_c6). Without it, ovf is tied to 0 and slice_c6
// is ignored.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. in_ready is 1 only in IDLE. out_valid is 1 only in DONE,
// and sum/co/ovf stay stable until out_valid & out_ready.
//
// dbg_state exposes the FSM state register for observation.
module mwadd_seq #(
  parameter int NSLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NSLICE-1:0]   a,
  input  logic [8*NSLICE-1:0]   b,
  input  logic                  ci,
  output logic [7:0]            slice_a,
  output logic [7:0]            slice_b,
  output logic                  slice_ci,
  input  logic [7:0]            slice_s,
  input  logic                  slice_c7,
  input  logic                  slice_c6,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NSLICE-1:0]   sum,
  output logic                  co,
  output logic                  ovf,
  output logic [1:0]            dbg_state
);

  localparam int W  = 8 * NSLICE;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    sum_reg;
  logic            co_reg;

  // FSM plus datapath registers; one slice is folded into sum_reg per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      co_reg  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            carry   <= ci;
            idx     <= '0;
            sum_reg <= '0;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          sum_reg[8*idx +: 8] <= slice_s;
          carry               <= slice_c7;
          if (idx == LAST) begin
            idx    <= '0;
            co_reg <= slice_c7;
            state  <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MWADD_OVF_EN
  logic ovf_reg;

  // Signed overflow of the whole word is the carry-in/carry-out disagreement of its sign bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (state == S_BUSY && idx == LAST) begin
      ovf_reg <= slice_c7 ^ slice_c6;
    end
  end

  assign ovf = ovf_reg;
`else
  logic unused_c6;
  assign unused_c6 = slice_c6;
  assign ovf       = 1'b0;
`endif

  // Adder operands come only from registers, and are zero outside BUSY
  always_comb begin
    slice_a  = 8'h00;
    slice_b  = 8'h00;
    slice_ci = 1'b0;
    if (state == S_BUSY) begin
      slice_a  = a_reg[8*idx +: 8];
      slice_b  = b_reg[8*idx +: 8];
      slice_ci = carry;
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign sum       = sum_reg;
  assign co        = co_reg;
  assign dbg_state = state;

endmodule

// File: tb/tb_mwadd_seq.sv
// Testbench for mwadd_seq (NSLICE=4) with a behavioural 8-bit slice adder.
module tb_mwadd_seq;

  localparam int NSLICE = 4;
  localparam int W      = 8 * NSLICE;
`ifdef MWADD_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ci;
  logic [7:0]    slice_a;
  logic [7:0]    slice_b;
  logic          slice_ci;
  logic [7:0]    slice_s;
  logic          slice_c7;
  logic          slice_c6;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          co;
  logic          ovf;
  logic [1:0]    dbg_state_unused;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W+1:0] exp_q[$];
  logic         last_sci1;

  mwadd_seq #(.NSLICE(NSLICE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci),
    .slice_a(slice_a), .slice_b(slice_b), .slice_ci(slice_ci),
    .slice_s(slice_s), .slice_c7(slice_c7), .slice_c6(slice_c6),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co), .ovf(ovf),
    .dbg_state(dbg_state_unused)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural external 8-bit adder
  logic [8:0] lo7;
  always_comb begin
    {slice_c7, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + 9'(slice_ci);
    lo7 = {2'b00, slice_a[6:0]} + {2'b00, slice_b[6:0]} + 9'(slice_ci);
    slice_c6 = lo7[7];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain word arithmetic, packed as {ovf, co, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] full;
    logic       v;
    full = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    v    = OVF_ON && (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {v, full};
  endfunction

  // driver: one full transaction, expected result already on exp_q
  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tci, input int hold);
    logic [7:0]   sa[0:7];
    logic         sci[0:7];
    logic [W+1:0] exp;
    logic [W+1:0] got;
    int           k;
    logic         done;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    a = ta; b = tb2; ci = tci; in_valid = 1'b1;
    @(negedge clk);
    // operands change and in_valid stays high while busy: must be ignored
    a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
    sa[0] = slice_a; sci[0] = slice_ci;
    check("busy_in_ready", 64'(in_ready), 64'd0);
    check("busy_out_valid", 64'(out_valid), 64'd0);
    k = 0; done = 1'b0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
      if (out_valid) done = 1'b1;
      else if (k < 8) begin
        sa[k] = slice_a; sci[k] = slice_ci;
        a = $urandom; b = $urandom;
      end
    end
    check("latency", 64'(k), 64'(NSLICE));
    if (!done) begin
      in_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    for (int i = 0; i < NSLICE; i++) check("slice_a_order", 64'(sa[i]), 64'(ta[8*i +: 8]));
    last_sci1 = sci[1];
    check("done_slice_zero", 64'({slice_a, slice_b, slice_ci}), 64'd0);
    got = {ovf, co, sum};
    exp = exp_q.pop_front();
    check("result", 64'(got), 64'(exp));
    for (int h = 0; h < hold; h++) begin
      a = $urandom; b = $urandom; in_valid = 1'b1;
      @(negedge clk);
      check("hold_result", 64'({ovf, co, sum}), 64'(exp));
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", 64'(out_valid), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf_raw;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h00000002, 32'h00000003, 1'b0, 32'h00000005, 1'b0, 1'b0};
    vecs[1] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[5] = '{32'h12345678, 32'h0FEDCBA9, 1'b1, 32'h22222222, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ci = 1'b0; last_sci1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({out_valid, sum, co, ovf, slice_a, slice_b, slice_ci}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // out_ready while idle has no effect
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_out_ready_valid", 64'(out_valid), 64'd0);
    check("idle_out_ready_ready", 64'(in_ready), 64'd1);

    // table-driven vectors
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({vecs[i].ovf_raw & OVF_ON, vecs[i].co, vecs[i].sum});
      run_txn(vecs[i].a, vecs[i].b, vecs[i].ci, (i == 3) ? 3 : 0);
      if (i == 1) check("carry_into_slice1", 64'(last_sci1), 64'd1);
    end

    // reset during third BUSY cycle
    @(negedge clk);
    a = 32'h01010101; b = 32'h01010101; ci = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", 64'({out_valid, sum, co, ovf, slice_a, slice_b, slice_ci}), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("midrst_no_out_valid", 64'(seen), 64'd0);
    end
    check("midrst_in_ready_after", 64'(in_ready), 64'd1);

    // randomized transactions against the model
    for (int t = 0; t < 30; t++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      if (t % 5 == 0) ra = 32'hFFFFFFFF;
      exp_q.push_back(model(ra, rb, rc));
      run_txn(ra, rb, rc, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
